// File: rtl/mouse_bounds_sequencer.sv
// Programs a PS/2 mouse controller with per-mode cursor bounds through a serial
// sequence of one-hot write strobes, with gap timing, back-pressure and restart.
module mouse_bounds_sequencer #(
  parameter int VALUE_W = 12,
  parameter int MODE_W  = 3,
  parameter int N_MODES = 4,
  parameter logic [N_MODES*VALUE_W-1:0] MIN_X_TAB = {12'd0, 12'd0, 12'd361, 12'd0},
  parameter logic [N_MODES*VALUE_W-1:0] MAX_X_TAB = {12'd1019, 12'd1019, 12'd645, 12'd1019},
  parameter logic [N_MODES*VALUE_W-1:0] MIN_Y_TAB = {12'd0, 12'd0, 12'd367, 12'd0},
  parameter logic [N_MODES*VALUE_W-1:0] MAX_Y_TAB = {12'd763, 12'd763, 12'd651, 12'd763},
  parameter logic [N_MODES-1:0]         CENTER_MASK = 4'b0010,
  parameter int WRITE_GAP = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MODE_W-1:0]  mode_in,
  input  logic               force_reprog,
  input  logic               ctl_busy,
  output logic [VALUE_W-1:0] value,
  output logic               setmax_x,
  output logic               setmax_y,
  output logic               setmin_x,
  output logic               setmin_y,
  output logic               set_x,
  output logic               set_y,
  output logic               busy,
  output logic               done,
  output logic [MODE_W-1:0]  active_mode,
  output logic               mode_err
);

  localparam int N_SLOTS = 1 << MODE_W;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  // Tables are widened to the full mode_in range so lookups need no range guard.
  logic [VALUE_W-1:0] min_x_arr [N_SLOTS];
  logic [VALUE_W-1:0] max_x_arr [N_SLOTS];
  logic [VALUE_W-1:0] min_y_arr [N_SLOTS];
  logic [VALUE_W-1:0] max_y_arr [N_SLOTS];
  logic [N_SLOTS-1:0] center_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_tab
      if (gi < N_MODES) begin : g_valid
        assign min_x_arr[gi]  = MIN_X_TAB[gi*VALUE_W +: VALUE_W];
        assign max_x_arr[gi]  = MAX_X_TAB[gi*VALUE_W +: VALUE_W];
        assign min_y_arr[gi]  = MIN_Y_TAB[gi*VALUE_W +: VALUE_W];
        assign max_y_arr[gi]  = MAX_Y_TAB[gi*VALUE_W +: VALUE_W];
        assign center_vec[gi] = CENTER_MASK[gi];
      end else begin : g_unused
        assign min_x_arr[gi]  = '0;
        assign max_x_arr[gi]  = '0;
        assign min_y_arr[gi]  = '0;
        assign max_y_arr[gi]  = '0;
        assign center_vec[gi] = 1'b0;
      end
    end
  endgenerate

  state_t             state_q, state_d;
  logic [2:0]         step_q, step_d;
  logic [3:0]         gap_q, gap_d;
  logic [MODE_W-1:0]  active_q, active_d;
  logic [5:0]         strobe_q, strobe_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mode_err_q, mode_err_d;

  logic               mode_valid;
  logic               mode_change;
  logic [2:0]         last_step;
  logic [VALUE_W:0]   sum_x, sum_y;
  logic [VALUE_W-1:0] step_value;

  assign mode_valid  = (32'(mode_in) < N_MODES);
  assign mode_change = mode_valid && (mode_in != active_q);
  assign last_step   = center_vec[active_q] ? 3'd5 : 3'd3;
  assign sum_x       = {1'b0, min_x_arr[active_q]} + {1'b0, max_x_arr[active_q]};
  assign sum_y       = {1'b0, min_y_arr[active_q]} + {1'b0, max_y_arr[active_q]};

  always_comb begin
    step_value = '0;
    case (step_q)
      3'd0:    step_value = max_x_arr[active_q];
      3'd1:    step_value = max_y_arr[active_q];
      3'd2:    step_value = min_x_arr[active_q];
      3'd3:    step_value = min_y_arr[active_q];
      3'd4:    step_value = sum_x[VALUE_W:1];
      3'd5:    step_value = sum_y[VALUE_W:1];
      default: step_value = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    gap_d      = gap_q;
    active_d   = active_q;
    strobe_d   = '0;
    value_d    = '0;
    mode_err_d = ~mode_valid;
    case (state_q)
      IDLE: begin
        if (mode_change) begin
          active_d = mode_in;
          state_d  = WRITE;
          step_d   = 3'd0;
        end else if (force_reprog) begin
          state_d = WRITE;
          step_d  = 3'd0;
        end
      end
      WRITE: begin
        if (mode_change) begin
          active_d = mode_in;
          step_d   = 3'd0;
        end else if (!ctl_busy) begin
          strobe_d = 6'd1 << step_q;
          value_d  = step_value;
          step_d   = step_q + 3'd1;
          // The last write always passes through GAP so done lags the final strobe.
          if (step_q == last_step) begin
            state_d = GAP;
            gap_d   = 4'(WRITE_GAP);
          end else if (WRITE_GAP > 0) begin
            state_d = GAP;
            gap_d   = 4'(WRITE_GAP - 1);
          end
        end
      end
      GAP: begin
        if (mode_change) begin
          active_d = mode_in;
          state_d  = WRITE;
          step_d   = 3'd0;
        end else if (gap_q == 4'd0) begin
          state_d = (step_q > last_step) ? IDLE : WRITE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WRITE;
      step_q     <= 3'd0;
      gap_q      <= 4'd0;
      active_q   <= '0;
      strobe_q   <= '0;
      value_q    <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      gap_q      <= gap_d;
      active_q   <= active_d;
      strobe_q   <= strobe_d;
      value_q    <= value_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign value       = value_q;
  assign setmax_x    = strobe_q[0];
  assign setmax_y    = strobe_q[1];
  assign setmin_x    = strobe_q[2];
  assign setmin_y    = strobe_q[3];
  assign set_x       = strobe_q[4];
  assign set_y       = strobe_q[5];
  assign busy        = busy_q;
  assign done        = done_q;
  assign active_mode = active_q;
  assign mode_err    = mode_err_q;

endmodule

// File: doc/mouse_bounds_sequencer.md
Name: mouse_bounds_sequencer

Overview:
Parametrised successor to the menu/game mouse constrainer. It holds a per-mode table of cursor bounds, with optional re-centring per mode. On reset, on a mode change or on a forced request, it issues a serial sequence of one-hot write strobes plus a value bus to the PS/2 mouse controller. It adds inter-write gap timing, controller back-pressure, abort/restart on mid-sequence mode change, invalid-mode rejection and status outputs.

Parameters:
VALUE_W, 12, width of value bus and table entries
MODE_W, 3, width of mode_in
N_MODES, 4, number of table entries (modes 0..N_MODES-1)
MIN_X_TAB, {0,0,361,0} (mode3..mode0, VALUE_W each), per-mode minimum X
MAX_X_TAB, {1019,1019,645,1019}, per-mode maximum X
MIN_Y_TAB, {0,0,367,0}, per-mode minimum Y
MAX_Y_TAB, {763,763,651,763}, per-mode maximum Y
CENTER_MASK, 4'b0010, bit m=1: mode m also writes set_x/set_y
WRITE_GAP, 0, idle cycles inserted after each strobe (0..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mode_in  in  MODE_W  requested mouse mode
force_reprog  in  1  one-cycle pulse: re-run sequence for active mode
ctl_busy  in  1  mouse controller cannot accept a write this cycle
value  out  VALUE_W  data accompanying the strobe
setmax_x, setmax_y, setmin_x, setmin_y, set_x, set_y  out  1 each  one-hot write strobes
busy  out  1  sequence in progress
done  out  1  active mode fully programmed
active_mode  out  MODE_W  mode currently programmed or being programmed
mode_err  out  1  mode_in >= N_MODES this cycle (registered)

Behaviour:
- All outputs registered. Reset values: value=0, all strobes=0, busy=1, done=0, active_mode=0, mode_err=0.
- States: IDLE, WRITE, GAP. Reset enters WRITE at step 0 for mode 0.
- Step order: 0 setmax_x=MAX_X, 1 setmax_y=MAX_Y, 2 setmin_x=MIN_X, 3 setmin_y=MIN_Y. If CENTER_MASK[mode]: 4 set_x=(MIN_X+MAX_X)>>1, 5 set_y=(MIN_Y+MAX_Y)>>1. Sums are computed at VALUE_W+1 bits, so no overflow. Last step is 3 or 5.
- WRITE: if ctl_busy=0, assert exactly one strobe plus value for one cycle, then advance the step. If ctl_busy=1, no strobe and the step is held. At most one strobe is high per cycle; value=0 whenever no strobe is high.
- After a strobe: if WRITE_GAP>0, go to GAP for WRITE_GAP cycles (strobes low), then WRITE. Otherwise go straight to WRITE.
- After the strobe of the last step, plus its gap if any: go to IDLE with busy=0 and done=1.
- Trigger in IDLE: mode_in valid and mode_in != active_mode, or force_reprog=1. On the trigger edge: active_mode<=mode_in (unchanged for force), busy=1, done=0, state=WRITE step 0. The first strobe appears on the next cycle.
- Mid-sequence change (WRITE or GAP, valid mode_in != active_mode): any strobe already registered completes. The sequence restarts at step 0 for the new mode, and the first new strobe is one cycle after the sampling edge. force_reprog during busy is ignored.
- Invalid mode (mode_in >= N_MODES): mode_err=1 next cycle. No trigger. active_mode and the current sequence are unaffected.
- Simultaneous invalid mode_in and force_reprog: reprogram the current active_mode.
- rst mid-sequence: all strobes drop on the next edge and the sequence restarts for mode 0.

Test Plan:
- Reset, mode_in=0, ctl_busy=0, WRITE_GAP=0 -> four consecutive strobes with values 1019, 763, 0, 0 -> done=1, busy=0, active_mode=0.
- mode_in 0->1 in IDLE -> one cycle later six strobes: 645, 651, 361, 367, 503 (set_x), 509 (set_y) -> done=1.
- WRITE_GAP=2, mode 1 -> each strobe followed by exactly 2 low cycles; done after 18 cycles from the first strobe.
- ctl_busy high for 3 cycles during step 2 -> setmin_x delayed 3 cycles, no strobe lost or duplicated.
- mode_in 1->0 after step 2 of mode 1 -> restart with setmax_x=1019, no set_x/set_y issued; mode_in=5 -> mode_err=1, no strobes, active_mode unchanged.
- force_reprog pulse in IDLE (mode 1) -> full six-write sequence repeats; rst asserted during step 3 -> strobes low, restart at mode 0.
